// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and decode helpers for the 6502 interrupt entry sequencer.
// States, source codes, vector-low constants and the per-state control decode.
package int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_C1   = 3'd1,
        ST_C2   = 3'd2,
        ST_C3   = 3'd3,
        ST_C4   = 3'd4,
        ST_C5   = 3'd5,
        ST_C6   = 3'd6,
        ST_C7   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_IRQ   = 2'd2,
        SRC_BRK   = 2'd3
    } src_t;

    localparam logic [7:0] VEC_NMI_LO   = 8'hFA;
    localparam logic [7:0] VEC_RESET_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO   = 8'hFE;

    typedef struct packed {
        logic busy;
        logic done;
        logic rw;
        logic pcl_adl;
        logic pch_adh;
        logic pcl_db;
        logic pch_db;
        logic p_db;
        logic s_adl;
        logic z_adl0;
        logic z_adl1;
        logic z_adl2;
        logic z_adh0;
        logic z_adh1_7;
        logic one_db4;
        logic s_dec;
        logic pc_inc;
        logic load_pcl;
        logic load_pch;
        logic set_i;
    } ctl_t;

    function automatic ctl_t ctl_idle();
        ctl_t c;
        c    = '0;
        c.rw = 1'b1;
        return c;
    endfunction

    function automatic logic [7:0] vec_low(input src_t src);
        logic [7:0] v;
        case (src)
            SRC_NMI:   v = VEC_NMI_LO;
            SRC_RESET: v = VEC_RESET_LO;
            default:   v = VEC_IRQ_LO;
        endcase
        return v;
    endfunction

    // ADL is precharged high, so the vector is formed by pulling its zero bits low.
    function automatic ctl_t ctl_decode(input state_t st, input src_t src);
        ctl_t       c;
        logic [7:0] vec;
        c   = ctl_idle();
        vec = vec_low(src);
        case (st)
            ST_IDLE: c = ctl_idle();
            ST_C1, ST_C2: begin
                c.busy    = 1'b1;
                c.pcl_adl = 1'b1;
                c.pch_adh = 1'b1;
                c.pc_inc  = (st == ST_C2) && (src == SRC_BRK);
            end
            ST_C3, ST_C4, ST_C5: begin
                c.busy     = 1'b1;
                c.s_adl    = 1'b1;
                c.z_adh1_7 = 1'b1;
                c.s_dec    = 1'b1;
                c.rw       = (src == SRC_RESET);
                c.pch_db   = (st == ST_C3);
                c.pcl_db   = (st == ST_C4);
                c.p_db     = (st == ST_C5);
                c.one_db4  = (st == ST_C5) && (src == SRC_BRK);
            end
            ST_C6: begin
                c.busy     = 1'b1;
                c.z_adl0   = ~vec[0];
                c.z_adl1   = ~vec[1];
                c.z_adl2   = ~vec[2];
                c.load_pcl = 1'b1;
                c.set_i    = 1'b1;
            end
            ST_C7: begin
                c.busy     = 1'b1;
                c.done     = 1'b1;
                c.z_adl1   = ~vec[1];
                c.z_adl2   = ~vec[2];
                c.load_pch = 1'b1;
            end
            default: c = ctl_idle();
        endcase
        return c;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Decoder-side bundle of the interrupt sequencer: boundary/source inputs and
// routing/strobe outputs. master = decoder side, slave = sequencer.
interface interrupt_sequencer_if;
    logic       i_sync;
    logic       i_brk_op;
    logic       i_nmi_n;
    logic       i_irq_n;
    logic       i_p_i;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_src;
    logic       o_pcl_adl;
    logic       o_pch_adh;
    logic       o_pcl_db;
    logic       o_pch_db;
    logic       o_p_db;
    logic       o_s_adl;
    logic       o_0_adl0;
    logic       o_0_adl1;
    logic       o_0_adl2;
    logic       o_0_adh0;
    logic       o_0_adh1_7;
    logic       o_1_db4;
    logic       o_rw;
    logic       o_s_dec;
    logic       o_pc_inc;
    logic       o_load_pcl;
    logic       o_load_pch;
    logic       o_set_i;

    modport master (
        output i_sync, i_brk_op, i_nmi_n, i_irq_n, i_p_i,
        input  o_busy, o_done, o_src, o_pcl_adl, o_pch_adh, o_pcl_db, o_pch_db,
               o_p_db, o_s_adl, o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0,
               o_0_adh1_7, o_1_db4, o_rw, o_s_dec, o_pc_inc, o_load_pcl,
               o_load_pch, o_set_i
    );

    modport slave (
        input  i_sync, i_brk_op, i_nmi_n, i_irq_n, i_p_i,
        output o_busy, o_done, o_src, o_pcl_adl, o_pch_adh, o_pcl_db, o_pch_db,
               o_p_db, o_s_adl, o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0,
               o_0_adh1_7, o_1_db4, o_rw, o_s_dec, o_pc_inc, o_load_pcl,
               o_load_pch, o_set_i
    );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge.sv
// NMI falling-edge latch. o_pending includes an edge seen this cycle so that an
// NMI arriving on the boundary cycle wins arbitration; i_clear consumes both.
module nmi_edge_detector (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_nmi_n,
    input  logic i_clear,
    output logic o_pending
);
    logic nmi_prev_r;
    logic pending_r;
    logic edge_s;

    assign edge_s    = nmi_prev_r & ~i_nmi_n;
    assign o_pending = pending_r | edge_s;

    // Previous-sample register and sticky pending flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nmi_prev_r <= 1'b1;
            pending_r  <= 1'b0;
        end else begin
            nmi_prev_r <= i_nmi_n;
            if (i_clear) begin
                pending_r <= 1'b0;
            end else if (edge_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// 7-cycle 6502 interrupt entry sequencer for RESET/NMI/IRQ/BRK. Outputs are
// registered decodes of the next state, so they always track the current state.
module interrupt_sequencer
    import int_seq_pkg::*;
#(
    parameter bit NMI_HIJACK       = 1'b1,
    parameter bit RESET_AUTO_START = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    interrupt_sequencer_if.slave  bus
);
    state_t state_r;
    state_t state_nxt_s;
    src_t   src_r;
    src_t   src_nxt_s;
    logic   reset_pending_r;
    logic   reset_pending_nxt_s;
    logic   nmi_pending_s;
    logic   nmi_clear_s;
    ctl_t   ctl_r;

    nmi_edge_detector u_nmi_edge (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_nmi_n   (bus.i_nmi_n),
        .i_clear   (nmi_clear_s),
        .o_pending (nmi_pending_s)
    );

    // Boundary arbitration, cycle sequencing and the C5 NMI hijack.
    always_comb begin
        state_nxt_s         = state_r;
        src_nxt_s           = src_r;
        reset_pending_nxt_s = reset_pending_r;
        nmi_clear_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (reset_pending_r) begin
                    src_nxt_s   = SRC_RESET;
                    state_nxt_s = ST_C1;
                end else if (bus.i_sync) begin
                    if (nmi_pending_s) begin
                        src_nxt_s   = SRC_NMI;
                        state_nxt_s = ST_C1;
                        nmi_clear_s = 1'b1;
                    end else if (!bus.i_irq_n && !bus.i_p_i) begin
                        src_nxt_s   = SRC_IRQ;
                        state_nxt_s = ST_C1;
                    end else if (bus.i_brk_op) begin
                        src_nxt_s   = SRC_BRK;
                        state_nxt_s = ST_C1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_C1: state_nxt_s = ST_C2;
            ST_C2: state_nxt_s = ST_C3;
            ST_C3: state_nxt_s = ST_C4;
            ST_C4: state_nxt_s = ST_C5;
            ST_C5: begin
                state_nxt_s = ST_C6;
                // Stack pushes are done; an NMI can still take over the vector fetch.
                if (NMI_HIJACK && nmi_pending_s &&
                    ((src_r == SRC_IRQ) || (src_r == SRC_BRK))) begin
                    src_nxt_s   = SRC_NMI;
                    nmi_clear_s = 1'b1;
                end else begin
                    src_nxt_s = src_r;
                end
            end
            ST_C6: state_nxt_s = ST_C7;
            ST_C7: begin
                state_nxt_s = ST_IDLE;
                if (src_r == SRC_RESET) begin
                    reset_pending_nxt_s = 1'b0;
                end else begin
                    reset_pending_nxt_s = reset_pending_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, source, reset request and registered control outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r         <= ST_IDLE;
            src_r           <= SRC_RESET;
            reset_pending_r <= RESET_AUTO_START;
            ctl_r           <= ctl_idle();
        end else begin
            state_r         <= state_nxt_s;
            src_r           <= src_nxt_s;
            reset_pending_r <= reset_pending_nxt_s;
            ctl_r           <= ctl_decode(state_nxt_s, src_nxt_s);
        end
    end

    assign bus.o_busy     = ctl_r.busy;
    assign bus.o_done     = ctl_r.done;
    assign bus.o_src      = src_r;
    assign bus.o_pcl_adl  = ctl_r.pcl_adl;
    assign bus.o_pch_adh  = ctl_r.pch_adh;
    assign bus.o_pcl_db   = ctl_r.pcl_db;
    assign bus.o_pch_db   = ctl_r.pch_db;
    assign bus.o_p_db     = ctl_r.p_db;
    assign bus.o_s_adl    = ctl_r.s_adl;
    assign bus.o_0_adl0   = ctl_r.z_adl0;
    assign bus.o_0_adl1   = ctl_r.z_adl1;
    assign bus.o_0_adl2   = ctl_r.z_adl2;
    assign bus.o_0_adh0   = ctl_r.z_adh0;
    assign bus.o_0_adh1_7 = ctl_r.z_adh1_7;
    assign bus.o_1_db4    = ctl_r.one_db4;
    assign bus.o_rw       = ctl_r.rw;
    assign bus.o_s_dec    = ctl_r.s_dec;
    assign bus.o_pc_inc   = ctl_r.pc_inc;
    assign bus.o_load_pcl = ctl_r.load_pcl;
    assign bus.o_load_pch = ctl_r.load_pch;
    assign bus.o_set_i    = ctl_r.set_i;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: per-cycle control, ADL and DB models
// checked against hand-derived expectations for each interrupt scenario.
module tb_interrupt_sequencer;
    import int_seq_pkg::*;

    localparam int IX_BUSY    = 19;
    localparam int IX_DONE    = 18;
    localparam int IX_RW      = 17;
    localparam int IX_PCL_ADL = 16;
    localparam int IX_PCH_ADH = 15;
    localparam int IX_PCL_DB  = 14;
    localparam int IX_PCH_DB  = 13;
    localparam int IX_P_DB    = 12;
    localparam int IX_S_ADL   = 11;
    localparam int IX_Z_ADH17 = 6;
    localparam int IX_DB4     = 5;
    localparam int IX_S_DEC   = 4;
    localparam int IX_PC_INC  = 3;
    localparam int IX_LD_PCL  = 2;
    localparam int IX_LD_PCH  = 1;
    localparam int IX_SET_I   = 0;

    localparam logic [19:0] CTL_MASK = 20'hFF8FF;
    localparam logic [19:0] CTL_IDLE = 20'h20000;
    localparam logic [7:0]  PCH_VAL  = 8'h12;
    localparam logic [7:0]  PCL_VAL  = 8'h34;
    localparam logic [7:0]  P_VAL    = 8'h20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    interrupt_sequencer_if bus ();

    interrupt_sequencer #(
        .NMI_HIJACK       (1'b1),
        .RESET_AUTO_START (1'b1)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    logic [19:0] obs_ctl;
    logic [7:0]  adl_obs;
    logic [7:0]  db_obs;

    assign obs_ctl = {bus.o_busy, bus.o_done, bus.o_rw, bus.o_pcl_adl, bus.o_pch_adh,
                      bus.o_pcl_db, bus.o_pch_db, bus.o_p_db, bus.o_s_adl,
                      bus.o_0_adl0, bus.o_0_adl1, bus.o_0_adl2, bus.o_0_adh0,
                      bus.o_0_adh1_7, bus.o_1_db4, bus.o_s_dec, bus.o_pc_inc,
                      bus.o_load_pcl, bus.o_load_pch, bus.o_set_i};
    assign adl_obs = ~{5'b00000, bus.o_0_adl2, bus.o_0_adl1, bus.o_0_adl0};
    assign db_obs  = (bus.o_pch_db ? PCH_VAL : 8'h00) | (bus.o_pcl_db ? PCL_VAL : 8'h00) |
                     (bus.o_p_db ? P_VAL : 8'h00) | (bus.o_1_db4 ? 8'h10 : 8'h00);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in C1; walks C1..C7 and the return to IDLE.
    task automatic expect_seq(input string name, input logic [1:0] src0, input logic [1:0] srcf,
                              input bit brk, input bit rsrc, input logic [7:0] vlo,
                              input logic [7:0] pexp, input int nmi_at);
        for (int c = 1; c <= 7; c++) begin
            logic [19:0] e;
            logic [7:0]  adl_e;
            logic [7:0]  db_e;
            e             = '0;
            e[IX_BUSY]    = 1'b1;
            e[IX_DONE]    = (c == 7);
            e[IX_RW]      = !((c >= 3) && (c <= 5) && !rsrc);
            e[IX_PCL_ADL] = (c <= 2);
            e[IX_PCH_ADH] = (c <= 2);
            e[IX_PC_INC]  = (c == 2) && brk;
            e[IX_S_ADL]   = (c >= 3) && (c <= 5);
            e[IX_Z_ADH17] = (c >= 3) && (c <= 5);
            e[IX_S_DEC]   = (c >= 3) && (c <= 5);
            e[IX_PCH_DB]  = (c == 3);
            e[IX_PCL_DB]  = (c == 4);
            e[IX_P_DB]    = (c == 5);
            e[IX_DB4]     = (c == 5) && brk;
            e[IX_LD_PCL]  = (c == 6);
            e[IX_SET_I]   = (c == 6);
            e[IX_LD_PCH]  = (c == 7);
            adl_e = (c == 6) ? vlo : ((c == 7) ? (vlo + 8'd1) : 8'hFF);
            db_e  = (c == 3) ? PCH_VAL : ((c == 4) ? PCL_VAL : ((c == 5) ? pexp : 8'h00));
            check_val($sformatf("%s C%0d ctl", name, c), {12'h000, obs_ctl & CTL_MASK}, {12'h000, e});
            check_val($sformatf("%s C%0d src", name, c), {30'd0, bus.o_src},
                      {30'd0, ((c <= 5) ? src0 : srcf)});
            check_val($sformatf("%s C%0d adl", name, c), {24'h0, adl_obs}, {24'h0, adl_e});
            check_val($sformatf("%s C%0d db", name, c), {24'h0, db_obs}, {24'h0, db_e});
            if (c == nmi_at) begin
                bus.i_nmi_n = 1'b0;
            end
            tick();
        end
        check_val($sformatf("%s return idle", name), {12'h000, obs_ctl}, {12'h000, CTL_IDLE});
    endtask

    initial begin
        bus.i_sync   = 1'b0;
        bus.i_brk_op = 1'b0;
        bus.i_nmi_n  = 1'b1;
        bus.i_irq_n  = 1'b1;
        bus.i_p_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset ctl", {12'h000, obs_ctl}, {12'h000, CTL_IDLE});
        check_val("reset src", {30'd0, bus.o_src}, 32'd0);

        // Auto-start RESET sequence with i_sync held low.
        rst_n = 1'b1;
        tick();
        expect_seq("RESET", SRC_RESET, SRC_RESET, 1'b0, 1'b1, 8'hFC, P_VAL, 0);
        bus.i_sync = 1'b1;
        tick();
        tick();
        check_val("no reset restart", {12'h000, obs_ctl}, {12'h000, CTL_IDLE});

        // BRK at a boundary.
        bus.i_brk_op = 1'b1;
        tick();
        bus.i_sync   = 1'b0;
        bus.i_brk_op = 1'b0;
        expect_seq("BRK", SRC_BRK, SRC_BRK, 1'b1, 1'b0, 8'hFE, 8'h30, 0);

        // IRQ masked by I, then accepted.
        bus.i_irq_n = 1'b0;
        bus.i_p_i   = 1'b1;
        bus.i_sync  = 1'b1;
        tick();
        tick();
        check_val("irq masked", {12'h000, obs_ctl}, {12'h000, CTL_IDLE});
        bus.i_p_i = 1'b0;
        tick();
        bus.i_sync = 1'b0;
        expect_seq("IRQ", SRC_IRQ, SRC_IRQ, 1'b0, 1'b0, 8'hFE, P_VAL, 0);

        // IRQ hijacked by an NMI edge in C4.
        bus.i_sync = 1'b1;
        tick();
        bus.i_sync  = 1'b0;
        bus.i_irq_n = 1'b1;
        expect_seq("HIJACK", SRC_IRQ, SRC_NMI, 1'b0, 1'b0, 8'hFA, P_VAL, 4);
        bus.i_sync = 1'b1;
        tick();
        tick();
        check_val("hijack no replay", {12'h000, obs_ctl}, {12'h000, CTL_IDLE});
        bus.i_sync  = 1'b0;
        bus.i_nmi_n = 1'b1;
        tick();

        // NMI edge and IRQ at the same boundary: NMI first, then IRQ.
        bus.i_irq_n = 1'b0;
        bus.i_p_i   = 1'b0;
        bus.i_nmi_n = 1'b0;
        bus.i_sync  = 1'b1;
        tick();
        bus.i_sync = 1'b0;
        expect_seq("NMI first", SRC_NMI, SRC_NMI, 1'b0, 1'b0, 8'hFA, P_VAL, 0);
        bus.i_sync = 1'b1;
        tick();
        bus.i_sync = 1'b0;
        expect_seq("IRQ after NMI", SRC_IRQ, SRC_IRQ, 1'b0, 1'b0, 8'hFE, P_VAL, 0);
        bus.i_irq_n = 1'b1;
        bus.i_nmi_n = 1'b1;
        tick();

        // Reset asserted in C4 of an NMI sequence.
        bus.i_nmi_n = 1'b0;
        bus.i_sync  = 1'b1;
        tick();
        bus.i_sync = 1'b0;
        check_val("abort NMI C1 src", {30'd0, bus.o_src}, {30'd0, SRC_NMI});
        tick();
        tick();
        tick();
        check_val("abort NMI C4 pcl_db", {31'd0, bus.o_pcl_db}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async reset ctl", {12'h000, obs_ctl}, {12'h000, CTL_IDLE});
        check_val("async reset src", {30'd0, bus.o_src}, 32'd0);
        bus.i_nmi_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        expect_seq("RESET after abort", SRC_RESET, SRC_RESET, 1'b0, 1'b1, 8'hFC, P_VAL, 0);
        bus.i_sync = 1'b1;
        repeat (3) tick();
        check_val("NMI not replayed", {12'h000, obs_ctl}, {12'h000, CTL_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the internal bus routing control lines for the 7-cycle 6502 interrupt entry: RESET, NMI, IRQ and BRK.
- Sits beside the instruction decoder. While busy, it owns the routing control lines (PC/P/S drives, open-drain zero forcing, DB4 force) and the R/W strobe.
- Arbitrates pending interrupt sources at instruction boundaries and selects the vector address FFFA/FFFC/FFFE.

Parameters:
- NMI_HIJACK, 1, when 1 a pending NMI seen at end of C5 redirects an IRQ/BRK sequence to the NMI vector.
- RESET_AUTO_START, 1, when 1 the sequence runs automatically after reset deassertion.

Ports:
- i_clk  in  1  system clock (phi)
- i_reset_n  in  1  asynchronous active-low reset
- i_sync  in  1  instruction boundary; arbitration is permitted this cycle
- i_brk_op  in  1  decoder has a BRK opcode at the boundary
- i_nmi_n  in  1  NMI line, falling-edge sensitive, already synchronised
- i_irq_n  in  1  IRQ line, level sensitive, already synchronised
- i_p_i  in  1  interrupt-disable flag from P
- o_busy  out  1  sequence in progress (C1..C7)
- o_done  out  1  single-cycle pulse in C7
- o_src  out  2  active source: 0 RESET, 1 NMI, 2 IRQ, 3 BRK
- o_pcl_adl, o_pch_adh, o_pcl_db, o_pch_db, o_p_db, o_s_adl  out  1 each  routing enables
- o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0, o_0_adh1_7  out  1 each  open-drain zero forces
- o_1_db4  out  1  force DB[4]=1 (B flag)
- o_rw  out  1  1 = read, 0 = write
- o_s_dec, o_pc_inc, o_load_pcl, o_load_pch, o_set_i  out  1 each  datapath strobes

Behaviour:
- Reset (async, any state): state=IDLE; every output 0 except o_rw=1; nmi_pending=0; reset_pending=RESET_AUTO_START.
- All outputs are registered-state decodes (Moore). Each output reflects the current state only; there is no same-cycle input-to-output path.
- NMI edge: nmi_pending is set on a 1->0 transition of i_nmi_n (previous-sample register). It is cleared on the cycle an NMI sequence enters C1, or on a hijack. A new edge during an NMI sequence re-arms pending.
- Arbitration (state IDLE, i_sync=1), priority order: reset_pending > nmi_pending > (i_irq_n=0 && i_p_i=0) > i_brk_op.
  - A winner latches o_src and moves to C1 on the next edge.
  - reset_pending is accepted without i_sync.
  - If no source wins, stay IDLE.
- States: IDLE -> C1 -> C2 -> ... -> C7 -> IDLE. No stalls. Latency from acceptance to o_done is 7 cycles.
- C1: pcl_adl, pch_adh; rw=1.
- C2: pcl_adl, pch_adh; rw=1; pc_inc=1 only for BRK.
- C3: s_adl, 0_adh1_7 (ADH=01); pch_db; s_dec; rw=0.
- C4: as C3, but pcl_db in place of pch_db.
- C5: as C3, but p_db in place of pch_db; 1_db4=1 only for BRK.
- Stack cycles for RESET: rw stays 1 (no writes) but s_dec still pulses in C3-C5.
- Hijack: with NMI_HIJACK=1, src IRQ/BRK, and nmi_pending=1 at end of C5, o_src becomes NMI and nmi_pending clears. Any 1_db4 already emitted is unaffected.
- C6: ADH=FF (no driver). ADL low vector: 0_adl0=1 always; NMI adds 0_adl2 (FA); RESET adds 0_adl1 (FC); IRQ/BRK add nothing (FE). load_pcl=1; set_i=1.
- C7: ADL = vector+1. NMI sets 0_adl2 (FB); RESET sets 0_adl1 (FD); IRQ/BRK set none (FF). load_pch=1; done=1. reset_pending clears on RESET completion.
- Simultaneous NMI edge and IRQ at a boundary: NMI wins. IRQ is not latched and is re-evaluated at the next boundary.
- o_busy=1 in C1..C7. Inputs other than i_nmi_n are ignored while busy.

Decomposition:
- Package int_seq_pkg:
  - state enum (IDLE, C1..C7)
  - source codes SRC_RESET/NMI/IRQ/BRK
  - vector-low constants 8'hFA/8'hFC/8'hFE
- Sub-module nmi_edge_detector: i_clk, i_reset_n, i_nmi_n, i_clear -> o_pending.

Test Plan:
- Release i_reset_n, hold i_sync=0 -> C1..C7 run; o_rw=1 throughout; the ADL model reads FC in C6 and FD in C7; o_done pulses at cycle 7; o_src=0.
- i_sync=1, i_brk_op=1 -> o_pc_inc in C2; writes in C3/C4/C5 carry PCH, PCL, P|0x10; ADL FE then FF; o_set_i in C6.
- Drop i_irq_n with i_p_i=1 at a boundary -> stays IDLE. Set i_p_i=0 -> sequence starts, o_src=2, vector FE/FF, o_1_db4 never asserted.
- IRQ sequence, i_nmi_n falling edge in C4 -> at C6 o_src=1, ADL FA/FB, nmi_pending clears, no second NMI sequence follows.
- i_nmi_n edge and i_irq_n=0 at the same boundary -> NMI sequence first; IRQ sequence starts at the next i_sync after return.
- Assert i_reset_n=0 during C4 of an NMI sequence -> outputs 0 asynchronously and o_rw=1. On release, a RESET sequence runs; the NMI is not replayed.
